// File: rtl/modulo_dispensador_rolhas_if.sv
// Bundled control/status signals between the cork-magazine controller and its environment.
// The master side drives enable/seal/hopper inputs; the slave side is the controller itself.
interface modulo_dispensador_rolhas_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             ve;
    logic             hop_ack;
    logic             hop_empty;
    logic             clr_err;
    logic             ro;
    logic [WIDTH-1:0] count;
    logic             low;
    logic             hop_req;
    logic             hop_fault;
    logic             err;

    modport master (
        output enable,
        output ve,
        output hop_ack,
        output hop_empty,
        output clr_err,
        input  ro,
        input  count,
        input  low,
        input  hop_req,
        input  hop_fault,
        input  err
    );

    modport slave (
        input  enable,
        input  ve,
        input  hop_ack,
        input  hop_empty,
        input  clr_err,
        output ro,
        output count,
        output low,
        output hop_req,
        output hop_fault,
        output err
    );
endinterface

// File: rtl/modulo_dispensador_rolhas.sv
// Cork-magazine controller: counts corks, consumes one per seal edge, refills from a hopper.
// Build option ROLHA_ERR_STICKY_EN makes err sticky (cleared by clr_err); otherwise err is a one-cycle pulse.
module modulo_dispensador_rolhas #(
    parameter int WIDTH    = 4,
    parameter int CAP      = 15,
    parameter int LOW_MARK = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    modulo_dispensador_rolhas_if.slave    bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REFILL = 1'b1;

    localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CAP_C  = WIDTH'(CAP);
    localparam logic [WIDTH-1:0] LOW_C  = WIDTH'(LOW_MARK);

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ve_d_r;
    logic             err_r;
    logic             err_nxt_s;

    logic             refill_s;
    logic             cons_s;
    logic             add_s;
    logic             empty_seal_s;
    logic             low_s;

    assign refill_s = (state_r == ST_REFILL);
    assign cons_s   = bus.enable & bus.ve & ~ve_d_r;
    // The CAP guard is redundant with the FSM exit rule but keeps the counter from ever wrapping.
    assign add_s    = refill_s & bus.hop_ack & ~bus.hop_empty & (count_r != CAP_C);
    assign empty_seal_s = cons_s & ~add_s & (count_r == ZERO_C);
    assign low_s    = (count_r <= LOW_C);

    // Next cork count: net zero on simultaneous add/consume, saturates at zero.
    always_comb begin
        count_nxt_s = count_r;
        if (add_s && !cons_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (cons_s && !add_s && (count_r != ZERO_C)) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Refill FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable && low_s && !bus.hop_empty) begin
                    state_nxt_s = ST_REFILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if ((count_nxt_s == CAP_C) || bus.hop_empty || !bus.enable) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REFILL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef ROLHA_ERR_STICKY_EN
    // Sticky error flag: a new empty seal takes priority over clr_err.
    always_comb begin
        err_nxt_s = err_r;
        if (empty_seal_s) begin
            err_nxt_s = 1'b1;
        end else if (bus.clr_err) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end
`else
    logic unused_clr_err_s;
    assign unused_clr_err_s = bus.clr_err;

    // Pulse error flag: high for exactly the cycle after an empty seal.
    always_comb begin
        err_nxt_s = 1'b0;
        if (empty_seal_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = 1'b0;
        end
    end
`endif

    // State, count, seal edge history and error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= ZERO_C;
            ve_d_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            ve_d_r  <= bus.ve;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.ro        = (count_r != ZERO_C);
    assign bus.count     = count_r;
    assign bus.low       = low_s;
    assign bus.hop_req   = refill_s;
    assign bus.hop_fault = bus.enable & low_s & bus.hop_empty & ~refill_s;
    assign bus.err       = err_r;

endmodule
